// File: rtl/xor_parity_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : xor_parity_arbiter (with leaf cell xor_gate)
// Brief   : Round-robin arbiter that serialises requester words through one
//           shared 1-bit XOR stage and returns a tagged parity result.
// Revision: 1.0 - initial release
// ============================================================================

module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module xor_parity_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic                    parity
);

  localparam int                 c_cnt_w     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt  = c_cnt_w'(DATA_W - 1);
  localparam logic [ID_W-1:0]    c_last_init = ID_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_sr;
  logic               r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic [ID_W-1:0]    r_cur_id;
  logic [ID_W-1:0]    r_last;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic               r_parity;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [N_REQ-1:0]   w_onehot;
  logic [DATA_W-1:0]  w_word;
  logic               w_xor;

  // Scan upward from the requester after the last grant, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_last) + k) % N_REQ;
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_word   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_word      = data[i*DATA_W +: DATA_W];
      end
    end
  end

  xor_gate u_xor (
    .a (r_acc),
    .b (r_sr[0]),
    .y (w_xor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_acc     <= 1'b0;
      r_cnt     <= '0;
      r_cur_id  <= '0;
      r_last    <= c_last_init;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_parity  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_found) begin
            r_sr     <= w_word;
            r_acc    <= 1'b0;
            r_cnt    <= '0;
            r_cur_id <= w_winner;
            r_last   <= w_winner;
            r_gnt    <= w_onehot;
            r_state  <= ST_SHIFT;
          end else begin
            r_gnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_acc  <= w_xor;
          r_sr   <= r_sr >> 1;
          r_cnt  <= r_cnt + c_cnt_w'(1);
          r_gnt  <= '0;
          r_done <= 1'b0;
          if (r_cnt == c_last_cnt) begin
            r_parity  <= w_xor;
            r_done    <= 1'b1;
            r_done_id <= r_cur_id;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = (r_state == ST_SHIFT);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign parity  = r_parity;

endmodule
`default_nettype wire
